// File: rtl/epu_request_loader.sv
// Request loader for the signature-verify engine: packs 32 words into sig/key/rhash,
// starts the engine, and returns one status beat. Optional stats build: EPU_LOADER_STATS_EN.
module epu_request_loader #(
    parameter int WORDS_PER_REQ  = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         axiclk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] sig,
    output logic [255:0] key,
    output logic [255:0] rhash,
    output logic         epu_valid,
    input  logic         epu_ready,
    input  logic         epu_result,
    output logic         st_valid,
    input  logic         st_ready,
    output logic [1:0]   st_code,
`ifdef EPU_LOADER_STATS_EN
    output logic [15:0]  stat_pass,
    output logic [15:0]  stat_fail,
    output logic [15:0]  stat_err,
`endif
    output logic [2:0]   state_dbg
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]      LAST_IDX = 5'(WORDS_PER_REQ - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_FAIL  = 2'd0;
    localparam logic [1:0] CODE_FRAME = 2'd2;
    localparam logic [1:0] CODE_TMO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        wcnt_q;
    logic [TO_W-1:0]   tcnt_q;
    logic [1:0]        st_code_q, code_d;
    logic [31:0]       word_q [WORDS_PER_REQ];
    logic              ready_q, result_q;
    logic              accept, code_ld, wcnt_clr, tcnt_clr, tcnt_inc;

    // Handshakes: a beat transfers on a rising axiclk edge where valid && ready are both
    // high; valid, once raised, holds its payload until that edge.

    always_ff @(posedge axiclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            st_code_q <= CODE_FAIL;
            ready_q   <= 1'b0;
            result_q  <= 1'b0;
            for (int i = 0; i < WORDS_PER_REQ; i++) word_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= epu_ready;
            result_q <= epu_result;
            if (accept) begin
                word_q[wcnt_q] <= in_data;
                wcnt_q         <= wcnt_q + 5'd1;
            end else if (wcnt_clr) begin
                wcnt_q <= '0;
            end
            if (tcnt_clr)      tcnt_q <= '0;
            else if (tcnt_inc) tcnt_q <= tcnt_q + 1'b1;
            if (code_ld) st_code_q <= code_d;
        end
    end

    // Completion uses the registered ready/result so the status beat trails the
    // engine's ready rise by at least two cycles.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        epu_valid = 1'b0;
        st_valid  = 1'b0;
        accept    = 1'b0;
        code_ld   = 1'b0;
        code_d    = st_code_q;
        wcnt_clr  = 1'b0;
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = ready_q;
                if (in_valid && ready_q) begin
                    accept = 1'b1;
                    if (in_last) begin
                        code_ld = 1'b1;
                        code_d  = CODE_FRAME;
                        state_d = S_REPORT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (wcnt_q == LAST_IDX && in_last) begin
                        state_d = S_ISSUE;
                    end else if (wcnt_q == LAST_IDX || in_last) begin
                        code_ld = 1'b1;
                        code_d  = CODE_FRAME;
                        state_d = S_REPORT;
                    end
                end
            end
            S_ISSUE: begin
                epu_valid = 1'b1;
                tcnt_clr  = 1'b1;
                state_d   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                tcnt_inc = 1'b1;
                if (!epu_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (tcnt_q == TO_LAST) begin
                    code_ld = 1'b1;
                    code_d  = CODE_TMO;
                    state_d = S_REPORT;
                end
            end
            S_WAIT_DONE: begin
                tcnt_inc = 1'b1;
                if (ready_q) begin
                    code_ld = 1'b1;
                    code_d  = {1'b0, result_q};
                    state_d = S_REPORT;
                end else if (tcnt_q == TO_LAST) begin
                    code_ld = 1'b1;
                    code_d  = CODE_TMO;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                st_valid = 1'b1;
                if (st_ready) begin
                    wcnt_clr = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign st_code   = st_code_q;
    assign state_dbg = state_q;

    for (genvar g = 0; g < 16; g++) begin : g_sig
        assign sig[32*g +: 32] = word_q[g];
    end
    for (genvar g = 0; g < 8; g++) begin : g_key_rhash
        assign key[32*g +: 32]   = word_q[16 + g];
        assign rhash[32*g +: 32] = word_q[24 + g];
    end

`ifdef EPU_LOADER_STATS_EN
    always_ff @(posedge axiclk or posedge rst) begin
        if (rst) begin
            stat_pass <= '0;
            stat_fail <= '0;
            stat_err  <= '0;
        end else if (st_valid && st_ready) begin
            case (st_code_q)
                2'd1:    if (stat_pass != 16'hFFFF) stat_pass <= stat_pass + 16'd1;
                2'd0:    if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 16'd1;
                default: if (stat_err  != 16'hFFFF) stat_err  <= stat_err  + 16'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_epu_request_loader.sv
// Directed bench for epu_request_loader: load/issue/report, framing errors, timeout
// (second instance with a short timeout) and asynchronous reset mid-load.
module tb_epu_request_loader;

    logic         axiclk = 1'b0;
    logic         rst, rst_to;
    logic [31:0]  in_data;
    logic         in_valid, in_last;
    logic         epu_ready, epu_result, st_ready;

    logic         in_ready, epu_valid, st_valid;
    logic [1:0]   st_code;
    logic [511:0] sig;
    logic [255:0] key, rhash;
    logic [2:0]   state_dbg;

    logic         to_in_ready, to_epu_valid, to_st_valid;
    logic [1:0]   to_st_code;
    logic [511:0] to_sig;
    logic [255:0] to_key, to_rhash;
    logic [2:0]   to_state_dbg;
`ifdef EPU_LOADER_STATS_EN
    logic [15:0]  stat_pass, stat_fail, stat_err;
    logic [15:0]  to_stat_pass, to_stat_fail, to_stat_err;
`endif

    bit           use_to = 1'b0;
    logic         cur_in_ready, cur_st_valid;
    logic [1:0]   cur_st_code;
    assign cur_in_ready = use_to ? to_in_ready : in_ready;
    assign cur_st_valid = use_to ? to_st_valid : st_valid;
    assign cur_st_code  = use_to ? to_st_code  : st_code;

    int errors  = 0;
    int checks  = 0;
    int vpulses = 0;

    epu_request_loader dut (
        .axiclk(axiclk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .sig(sig), .key(key), .rhash(rhash),
        .epu_valid(epu_valid), .epu_ready(epu_ready), .epu_result(epu_result),
        .st_valid(st_valid), .st_ready(st_ready), .st_code(st_code),
`ifdef EPU_LOADER_STATS_EN
        .stat_pass(stat_pass), .stat_fail(stat_fail), .stat_err(stat_err),
`endif
        .state_dbg(state_dbg)
    );

    epu_request_loader #(.TIMEOUT_CYCLES(50)) dut_to (
        .axiclk(axiclk), .rst(rst_to),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(to_in_ready),
        .sig(to_sig), .key(to_key), .rhash(to_rhash),
        .epu_valid(to_epu_valid), .epu_ready(epu_ready), .epu_result(epu_result),
        .st_valid(to_st_valid), .st_ready(st_ready), .st_code(to_st_code),
`ifdef EPU_LOADER_STATS_EN
        .stat_pass(to_stat_pass), .stat_fail(to_stat_fail), .stat_err(to_stat_err),
`endif
        .state_dbg(to_state_dbg)
    );

    // Clock/reset: 10 ns period; inputs change on the falling edge, outputs sampled there too.
    always #5 axiclk = ~axiclk;

    always @(posedge axiclk) if (epu_valid) vpulses <= vpulses + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int req, input int idx);
        return {8'hA5, 8'(req), 16'(idx * 3 + 1)};
    endfunction

    // Driver: present one word and wait (bounded) for the transfer edge.
    task automatic send_word(input logic [31:0] d, input logic l, output bit ok);
        ok = 1'b0;
        in_data = d; in_valid = 1'b1; in_last = l;
        for (int g = 0; g < 20; g++) begin
            #1;
            if (cur_in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge axiclk);
        end
        @(negedge axiclk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_req(input int req, input int n, input int last_at);
        bit ok;
        int n_ok;
        n_ok = 0;
        for (int i = 0; i < n; i++) begin
            send_word(wd(req, i), (i == last_at), ok);
            if (ok) n_ok++;
        end
        check_eq($sformatf("words_accepted_r%0d", req), 64'(n_ok), 64'(n));
    endtask

    // Engine model: ready drops after the start pulse, rises `delay` cycles later.
    task automatic engine(input int delay, input logic res);
        bit seen, busy_rdy;
        seen = 1'b0; busy_rdy = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (epu_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge axiclk);
        end
        check_eq("epu_valid_seen", 64'(seen), 64'd1);
        @(negedge axiclk);
        epu_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        for (int g = 0; g < delay; g++) begin
            @(negedge axiclk);
            #1;
            if (in_ready) busy_rdy = 1'b1;
        end
        in_valid = 1'b0; epu_result = res; epu_ready = 1'b1;
        check_eq("in_ready_while_busy", 64'(busy_rdy), 64'd0);
    endtask

    task automatic wait_status(output logic [1:0] code, output int lat);
        bit seen;
        seen = 1'b0; lat = 0;
        for (int g = 0; g < 300; g++) begin
            if (cur_st_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge axiclk);
            lat++;
        end
        check_eq("st_valid_seen", 64'(seen), 64'd1);
        code = cur_st_code;
    endtask

    task automatic handshake();
        st_ready = 1'b1;
        @(negedge axiclk);
        st_ready = 1'b0;
        check_eq("st_valid_clear_after_hs", 64'(cur_st_valid), 64'd0);
    endtask

    logic [1:0] code;
    int         lat, p0, n;
    bit         stable, seen;

    initial begin
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        epu_ready = 1'b1; epu_result = 1'b0; st_ready = 1'b0;
        rst = 1'b1; rst_to = 1'b1;
        repeat (2) @(negedge axiclk);

        check_eq("rst_in_ready",  64'(in_ready),  64'd0);
        check_eq("rst_epu_valid", 64'(epu_valid), 64'd0);
        check_eq("rst_st_valid",  64'(st_valid),  64'd0);
        check_eq("rst_st_code",   64'(st_code),   64'd0);
        check_eq("rst_sig_zero",  64'(|sig),      64'd0);
        check_eq("rst_key_zero",  64'(|key),      64'd0);
        check_eq("rst_rhash_zero", 64'(|rhash),   64'd0);
        check_eq("rst_state",     64'(state_dbg), 64'd0);

        rst = 1'b0;
        repeat (2) @(negedge axiclk);
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);

        // Full request, pass verdict after 100 busy cycles.
        p0 = vpulses;
        send_req(1, 32, 31);
        engine(100, 1'b1);
        wait_status(code, lat);
        check_eq("t1_code", 64'(code), 64'd1);
        check_eq("t1_latency_ge2", 64'(lat >= 2), 64'd1);
        check_eq("t1_pulses", 64'(vpulses - p0), 64'd1);
        check_eq("t1_sig_w0", 64'(sig[31:0]), 64'(wd(1, 0)));
        check_eq("t1_sig_w15", 64'(sig[511:480]), 64'(wd(1, 15)));
        check_eq("t1_key_w16", 64'(key[31:0]), 64'(wd(1, 16)));
        check_eq("t1_rhash_w31", 64'(rhash[255:224]), 64'(wd(1, 31)));
        handshake();

        // Fail verdict, status held while consumer stalls for 20 cycles.
        send_req(2, 32, 31);
        engine(30, 1'b0);
        wait_status(code, lat);
        stable = 1'b1;
        for (int g = 0; g < 20; g++) begin
            @(negedge axiclk);
            if (!(st_valid === 1'b1 && st_code === 2'd0)) stable = 1'b0;
        end
        check_eq("t2_hold_stable", 64'(stable), 64'd1);
        check_eq("t2_code", 64'(st_code), 64'd0);
        handshake();

        // Early in_last on word 10, then a clean request.
        p0 = vpulses;
        send_req(3, 11, 10);
        wait_status(code, lat);
        check_eq("t3_code_frame", 64'(code), 64'd2);
        check_eq("t3_no_pulse", 64'(vpulses - p0), 64'd0);
        handshake();
        send_req(4, 32, 31);
        engine(5, 1'b1);
        wait_status(code, lat);
        check_eq("t3b_code", 64'(code), 64'd1);
        check_eq("t3b_sig_w0", 64'(sig[31:0]), 64'(wd(4, 0)));
        check_eq("t3b_sig_w10", 64'(sig[351:320]), 64'(wd(4, 10)));
        check_eq("t3b_rhash_w31", 64'(rhash[255:224]), 64'(wd(4, 31)));
        handshake();

        // 32 words without in_last.
        p0 = vpulses;
        send_req(5, 32, -1);
        wait_status(code, lat);
        check_eq("t4_code_frame", 64'(code), 64'd2);
        repeat (3) @(negedge axiclk);
        check_eq("t4_no_pulse", 64'(vpulses - p0), 64'd0);
        handshake();
`ifdef EPU_LOADER_STATS_EN
        check_eq("t4_stat_pass", 64'(stat_pass), 64'd2);
        check_eq("t4_stat_fail", 64'(stat_fail), 64'd1);
        check_eq("t4_stat_err",  64'(stat_err),  64'd2);
`endif

        // Timeout on the 50-cycle instance: engine drops ready and never raises it.
        rst = 1'b1; use_to = 1'b1; rst_to = 1'b0;
        repeat (2) @(negedge axiclk);
        send_req(8, 32, 31);
        seen = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (to_epu_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge axiclk);
        end
        check_eq("t5_epu_valid_seen", 64'(seen), 64'd1);
        n = 0; seen = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge axiclk);
            epu_ready = 1'b0;
            n++;
            if (to_st_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t5_status_seen", 64'(seen), 64'd1);
        check_eq("t5_cycles_to_status", 64'(n), 64'd51);
        check_eq("t5_code_timeout", 64'(to_st_code), 64'd3);
        handshake();
        repeat (3) @(negedge axiclk);
        check_eq("t5_in_ready_held_low", 64'(to_in_ready), 64'd0);
        epu_ready = 1'b1;
        @(negedge axiclk);
        check_eq("t5_in_ready_after_ready", 64'(to_in_ready), 64'd1);

        // Asynchronous reset in the middle of word 17.
        rst_to = 1'b1; use_to = 1'b0; rst = 1'b0;
        repeat (2) @(negedge axiclk);
        send_req(6, 17, -1);
        check_eq("t6_sig_w0_loaded", 64'(sig[31:0]), 64'(wd(6, 0)));
        in_data = wd(6, 17); in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("t6_rst_state", 64'(state_dbg), 64'd0);
        check_eq("t6_rst_sig_zero", 64'(|sig), 64'd0);
        check_eq("t6_rst_st_valid", 64'(st_valid), 64'd0);
        check_eq("t6_rst_epu_valid", 64'(epu_valid), 64'd0);
        in_valid = 1'b0;
        @(negedge axiclk);
        rst = 1'b0;
        repeat (2) @(negedge axiclk);
        send_req(7, 32, 31);
        engine(10, 1'b1);
        wait_status(code, lat);
        check_eq("t6_code", 64'(code), 64'd1);
        check_eq("t6_sig_w0", 64'(sig[31:0]), 64'(wd(7, 0)));
        handshake();
`ifdef EPU_LOADER_STATS_EN
        check_eq("t6_stat_pass", 64'(stat_pass), 64'd1);
        check_eq("t6_stat_fail", 64'(stat_fail), 64'd0);
        check_eq("t6_stat_err",  64'(stat_err),  64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
